mem_port_client: RTL and testbench
==================================

Name: mem_port_client

Overview:
- Per-core initiator for the shared-memory arbitrated port: the data read/write path that each core drives toward the dual-core memory.
- Accepts one load or store at a time from the core over a valid/ready handshake.
- Drives the memory's valid-tagged read and write address buses, and checks the core tag on the returned read data.
- Retries transparently when the memory's fixed-priority arbitration (core A wins) drops the request.

Parameters:
- CORE_ID, 0, Which core this instance serves. 0 = core A (priority), 1 = core B. Compared against the response tag bit.
- MAX_RETRY, 0, Maximum retries per request. 0 = unlimited. On overflow the request ends with rsp_err.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  client idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  15  word address [15:1]
- req_wdata  in  16  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  16  load data; 0 for stores
- rsp_err  out  1  qualifies rsp_valid; retry limit exceeded
- raddr_o  out  16  memory read bus [16:1]; bit16 = read valid, [15:1] = address
- waddr_o  out  16  memory write bus [16:1]; bit16 = write valid
- wdata_o  out  16  memory write data
- rdata_i  in  17  memory tagged read data; bit16 = core tag (0 = A, 1 = B), [15:0] = data
- peer_wvalid_i  in  1  other core's write-valid bit, snooped to detect a lost store

Behaviour:
- Reset values: state IDLE; req_ready=0 while reset is high; rsp_valid=0; rsp_err=0; rsp_data=0; raddr_o=0; waddr_o=0; wdata_o=0; retry count=0.
- States: IDLE, ISSUE, WAIT, CHECK.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we, addr and wdata, then go to ISSUE.
- ISSUE (one cycle):
  - Load: raddr_o={1,addr}; go to WAIT.
  - Store: waddr_o={1,addr}, wdata_o=wdata.
  - Store is lost when CORE_ID==1 && peer_wvalid_i==1 in this cycle: count a retry and stay in ISSUE.
  - Otherwise the store is complete: go to IDLE and pulse rsp_valid in the next cycle.
- WAIT: one cycle, buses idle (valid bits 0); go to CHECK. Memory read latency is 2 clocks from the ISSUE cycle.
- CHECK:
  - If rdata_i[16]==CORE_ID: register rsp_data=rdata_i[15:0], pulse rsp_valid next cycle, go to IDLE.
  - Otherwise count a retry and go to ISSUE.
- Retry limit: if MAX_RETRY!=0 and the retry count reaches MAX_RETRY on a failed attempt, go to IDLE and pulse rsp_valid with rsp_err=1 and rsp_data=0.
- Retry count clears on every acceptance.
- Latency (acceptance edge = cycle 0, no retries):
  - Load: ISSUE c1, WAIT c2, CHECK c3, rsp_valid c4.
  - Store: ISSUE c1, rsp_valid c2.
  - Each load retry adds 3 cycles; each store retry adds 1.
- req_ready is 1 in the same cycle rsp_valid pulses, so back-to-back requests are allowed.
- Valid bits outside ISSUE are 0. Address and data fields hold their last value.
- CORE_ID=0 keeps the CHECK comparison and ignores peer_wvalid_i.
- Reset mid-operation: abort at the next edge. Any in-flight memory response is ignored and no rsp_valid is produced.
- req fields are sampled only on acceptance; changes while busy have no effect.

Optional Feature:
- Macro: MEM_PORT_RETRY_STATS_EN.
- When defined:
  - Adds output retry_total (16 bits): cumulative retries since reset, saturating at 16'hffff.
  - Adds output stall_cycles (16 bits): cycles not in IDLE, saturating at 16'hffff.
  - Both reset to 0.
- When undefined: both ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Shared package mem_port_pkg:
  - state enum.
  - ADDR_W=15, DATA_W=16.
  - CORE_A=0, CORE_B=1.
  - MEM_RD_LAT=2.
  - VALID_BIT=16 (bus valid/tag bit index).
- No sub-module: a single FSM plus a retry counter is below the size where a split pays off.

Test Plan:
- CORE_ID=0, load addr 15'h0010 holding 16'hbeef -> raddr_o=17'h... with bit16=1 in c1; rsp_valid with rsp_data=16'hbeef in c4; req_ready=1 in c4.
- CORE_ID=1, load addr 15'h0020; core A model reads in the same c1 -> tag 0 in CHECK, one retry; rsp_valid in c7 with correct data.
- CORE_ID=1, store 16'h1234 to 15'h0030 with peer_wvalid_i=1 for 2 cycles -> waddr_o valid for 3 consecutive cycles; rsp_valid in c4; memory word equals 16'h1234.
- CORE_ID=1, MAX_RETRY=2, peer reads every cycle -> rsp_valid with rsp_err=1, rsp_data=0 after 2 retries (c7); next request accepted.
- Reset asserted in WAIT of a load -> next cycle state IDLE, all valid bits 0, no rsp_valid ever for that load.
- Back-to-back: store then load to the same address 15'h0040 with no gaps -> load returns the stored value; with MEM_PORT_RETRY_STATS_EN, retry_total=0 and stall_cycles=4.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Purpose : shared types and constants for the per-core shared-memory port client.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package mem_port_pkg;

    localparam int ADDR_W     = 15;  // word address, carried on bus bits [15:1]
    localparam int DATA_W     = 16;
    localparam int CORE_A     = 0;   // arbitration winner
    localparam int CORE_B     = 1;
    localparam int MEM_RD_LAT = 2;   // clocks from ISSUE until read data is on rdata_i
    localparam int VALID_BIT  = 16;  // valid bit on the address buses, tag bit on rdata
    localparam int CNT_W      = 16;  // retry / statistics counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_port_client.sv
// Purpose : per-core initiator onto the dual-core shared memory; one load/store in flight,
//           transparent retry when the fixed-priority arbiter (core A wins) drops the access.
// Latency : load 4 cycles acceptance->rsp_valid, store 2; +3 per load retry, +1 per store retry.
// Backpressure: req_ready is high only in IDLE (and low during reset); it is high in the
//           rsp_valid cycle, so requests may run back to back.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready core request handshake; req_we, req_addr, req_wdata sampled on acceptance
//   rsp_valid           one-cycle completion pulse, qualified by rsp_err; rsp_data = load data
//   raddr_o, waddr_o    memory read/write buses, bit 16 = valid, [15:1] = word address
//   wdata_o             memory write data
//   rdata_i             memory read data, bit 16 = tag of the core that won the read
//   peer_wvalid_i       other core's write-valid bit, used by core B to spot a lost store
//   retry_total, stall_cycles   statistics outputs, present only with MEM_PORT_RETRY_STATS_EN
//
// Optional build macro: MEM_PORT_RETRY_STATS_EN adds the saturating statistics counters.
module mem_port_client
    import mem_port_pkg::*;
#(
    parameter int CORE_ID   = 0,  // 0 = core A (priority), 1 = core B
    parameter int MAX_RETRY = 0   // 0 = retry forever
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    output logic [VALID_BIT:1]   raddr_o,
    output logic [VALID_BIT:1]   waddr_o,
    output logic [DATA_W-1:0]    wdata_o,
    input  logic [VALID_BIT:0]   rdata_i,
`ifdef MEM_PORT_RETRY_STATS_EN
    output logic [CNT_W-1:0]     retry_total,
    output logic [CNT_W-1:0]     stall_cycles,
`endif
    input  logic                 peer_wvalid_i
);

    // Tag value the memory returns when this core owned the read.
    localparam logic            CORE_TAG  = (CORE_ID == CORE_A) ? 1'b0 : 1'b1;
    // Only the lower-priority core can lose a write to its peer.
    localparam bit              SNOOP_EN  = (CORE_ID != CORE_A);
    localparam bit              LIMIT_EN  = (MAX_RETRY != 0);
    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);

    state_e                r_state;
    state_e                w_next_state;

    logic                  r_we;
    logic [ADDR_W-1:0]     r_rd_addr;   // address field of the read bus
    logic [ADDR_W-1:0]     r_wr_addr;   // address field of the write bus
    logic [DATA_W-1:0]     r_wr_data;
    logic [CNT_W-1:0]      r_retry_cnt;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_W-1:0]     r_rsp_data;

    logic                  w_req_ready;
    logic                  w_rd_vld;
    logic                  w_wr_vld;
    logic                  w_accept;
    logic                  w_in_issue;
    logic                  w_in_check;
    logic                  w_store_lost;
    logic                  w_tag_ok;
    logic                  w_load_miss;
    logic                  w_attempt_fail;
    logic [CNT_W-1:0]      w_retry_inc;
    logic                  w_limit_hit;
    logic                  w_store_done;
    logic                  w_load_done;

    // ------------------------------------------------------------------
    // Attempt outcome decode
    // ------------------------------------------------------------------
    assign w_in_issue     = (r_state == ST_ISSUE);
    assign w_in_check     = (r_state == ST_CHECK);
    assign w_accept       = req_valid && w_req_ready;

    // Core A's write wins the same cycle, so ours never reached the array.
    assign w_store_lost   = w_in_issue && r_we && SNOOP_EN && peer_wvalid_i;
    // Read data belongs to whichever core won the ISSUE cycle two clocks ago.
    assign w_tag_ok       = (rdata_i[VALID_BIT] == CORE_TAG);
    assign w_load_miss    = w_in_check && !w_tag_ok;
    assign w_attempt_fail = w_store_lost || w_load_miss;

    // The failure being counted now is included when testing the limit.
    assign w_retry_inc    = sat_inc(r_retry_cnt);
    assign w_limit_hit    = w_attempt_fail && LIMIT_EN && (w_retry_inc >= RETRY_LIM);

    assign w_store_done   = w_in_issue && r_we && !w_store_lost;
    assign w_load_done    = w_in_check && w_tag_ok;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!r_we) begin
                    w_next_state = ST_WAIT;
                end else if (w_store_lost) begin
                    w_next_state = w_limit_hit ? ST_IDLE : ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Single bubble covers the MEM_RD_LAT=2 read pipeline.
                w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_tag_ok) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = w_limit_hit ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_req_ready = 1'b0;
        w_rd_vld    = 1'b0;
        w_wr_vld    = 1'b0;
        case (r_state)
            ST_IDLE:  w_req_ready = !reset;
            ST_ISSUE: begin
                w_rd_vld = !r_we;
                w_wr_vld = r_we;
            end
            default: begin
                w_req_ready = 1'b0;
            end
        endcase
    end

    // Address/data fields keep their last value; only the valid bits drop.
    assign req_ready = w_req_ready;
    assign raddr_o   = {w_rd_vld, r_rd_addr};
    assign waddr_o   = {w_wr_vld, r_wr_addr};
    assign wdata_o   = r_wr_data;

    // ------------------------------------------------------------------
    // Request capture, retry counter, response
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we        <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_retry_cnt <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;

            if (w_accept) begin
                r_we        <= req_we;
                r_retry_cnt <= '0;
                // Only the bus this access uses picks up new fields.
                if (req_we) begin
                    r_wr_addr <= req_addr;
                    r_wr_data <= req_wdata;
                end else begin
                    r_rd_addr <= req_addr;
                end
            end

            if (w_attempt_fail) begin
                r_retry_cnt <= w_retry_inc;
            end

            if (w_store_done || w_load_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= w_load_done ? rdata_i[DATA_W-1:0] : '0;
            end else if (w_limit_hit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_rsp_data  <= '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;

`ifdef MEM_PORT_RETRY_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: every failed attempt, and every non-IDLE cycle
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_retry_total;
    logic [CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry_total  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_attempt_fail) begin
                r_retry_total <= sat_inc(r_retry_total);
            end
            if (r_state != ST_IDLE) begin
                r_stall_cycles <= sat_inc(r_stall_cycles);
            end
        end
    end

    assign retry_total  = r_retry_total;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_mem_port_client.sv
module tb_mem_port_client;
    import mem_port_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        va, vb, vc;
    logic        req_we;
    logic [14:0] req_addr;
    logic [15:0] req_wdata;

    logic        rdy_a, rv_a, re_a;
    logic [15:0] rd_a, wd_a;
    logic [16:1] ra_a, wa_a;
    logic        rdy_b, rv_b, re_b;
    logic [15:0] rd_b, wd_b;
    logic [16:1] ra_b, wa_b;
    logic        rdy_c, rv_c, re_c;
    logic [15:0] rd_c, wd_c;
    logic [16:1] ra_c, wa_c;
`ifdef MEM_PORT_RETRY_STATS_EN
    logic [15:0] rt_a, sc_a, rt_b, sc_b, rt_c, sc_c;
`endif

    // Fake core A used to create arbitration conflicts for the core-B instances.
    logic        fk_rd, fk_wr;
    logic [14:0] fk_raddr, fk_waddr;
    logic [15:0] fk_wdata;

    // Shared memory model: fixed priority, A side wins, 2-clock read latency.
    logic [15:0] mem [0:32767];
    logic [16:0] rd_p1, rd_p2, rdata;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [14:0] a_raddr, a_waddr, b_raddr, b_waddr;
    logic [15:0] a_wdata, b_wdata;

    assign a_rd    = ra_a[16] | fk_rd;
    assign a_raddr = fk_rd ? fk_raddr : ra_a[15:1];
    assign a_wr    = wa_a[16] | fk_wr;
    assign a_waddr = fk_wr ? fk_waddr : wa_a[15:1];
    assign a_wdata = fk_wr ? fk_wdata : wd_a;
    assign b_rd    = ra_b[16] | ra_c[16];
    assign b_raddr = ra_b[16] ? ra_b[15:1] : ra_c[15:1];
    assign b_wr    = wa_b[16] | wa_c[16];
    assign b_waddr = wa_b[16] ? wa_b[15:1] : wa_c[15:1];
    assign b_wdata = wa_b[16] ? wd_b : wd_c;
    assign rdata   = rd_p2;

    always @(posedge clk) begin
        if (a_rd)      rd_p1 <= {1'b0, mem[a_raddr]};
        else if (b_rd) rd_p1 <= {1'b1, mem[b_raddr]};
        else           rd_p1 <= 17'h0;
        rd_p2 <= rd_p1;
        if (a_wr)      mem[a_waddr] <= a_wdata;
        else if (b_wr) mem[b_waddr] <= b_wdata;
    end

    mem_port_client #(.CORE_ID(0), .MAX_RETRY(0)) u_a (
        .clk(clk), .reset(reset), .req_valid(va), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_data(rd_a),
        .rsp_err(re_a), .raddr_o(ra_a), .waddr_o(wa_a), .wdata_o(wd_a), .rdata_i(rdata),
`ifdef MEM_PORT_RETRY_STATS_EN
        .retry_total(rt_a), .stall_cycles(sc_a),
`endif
        .peer_wvalid_i(b_wr));

    mem_port_client #(.CORE_ID(1), .MAX_RETRY(0)) u_b (
        .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_data(rd_b),
        .rsp_err(re_b), .raddr_o(ra_b), .waddr_o(wa_b), .wdata_o(wd_b), .rdata_i(rdata),
`ifdef MEM_PORT_RETRY_STATS_EN
        .retry_total(rt_b), .stall_cycles(sc_b),
`endif
        .peer_wvalid_i(a_wr));

    mem_port_client #(.CORE_ID(1), .MAX_RETRY(2)) u_c (
        .clk(clk), .reset(reset), .req_valid(vc), .req_ready(rdy_c), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_c), .rsp_data(rd_c),
        .rsp_err(re_c), .raddr_o(ra_c), .waddr_o(wa_c), .wdata_o(wd_c), .rdata_i(rdata),
`ifdef MEM_PORT_RETRY_STATS_EN
        .retry_total(rt_c), .stall_cycles(sc_c),
`endif
        .peer_wvalid_i(a_wr));

    // Outputs of the instance currently under test.
    int          cur;
    logic        cur_rdy, cur_rv, cur_re;
    logic [15:0] cur_rd, cur_wd;
    logic [16:1] cur_ra, cur_wa;
    always_comb begin
        cur_rdy = rdy_a; cur_rv = rv_a; cur_re = re_a; cur_rd = rd_a;
        cur_wd  = wd_a;  cur_ra = ra_a; cur_wa = wa_a;
        if (cur == 1) begin
            cur_rdy = rdy_b; cur_rv = rv_b; cur_re = re_b; cur_rd = rd_b;
            cur_wd  = wd_b;  cur_ra = ra_b; cur_wa = wa_b;
        end else if (cur == 2) begin
            cur_rdy = rdy_c; cur_rv = rv_c; cur_re = re_c; cur_rd = rd_c;
            cur_wd  = wd_c;  cur_ra = ra_c; cur_wa = wa_c;
        end
    end

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [16:1] cap_ra  [0:31];
    logic [16:1] cap_wa  [0:31];
    logic [15:0] cap_wd  [0:31];
    logic        cap_rdy [0:31];
    int          rsp_cyc;

    // Issue one request; the expected completion goes on the scoreboard (exp_lat<0: none).
    task automatic do_req(input int which, input logic we, input logic [14:0] addr,
                          input logic [15:0] wd, input int exp_lat,
                          input logic [15:0] exp_data, input logic exp_err, input bit b2b);
        exp_t e;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        cur = which; req_we = we; req_addr = addr; req_wdata = wd;
        if (which == 0) va = 1'b1;
        else if (which == 1) vb = 1'b1;
        else vc = 1'b1;
        if (exp_lat >= 0) begin
            e.lat = exp_lat; e.data = exp_data; e.err = exp_err;
            sb.push_back(e);
        end
        if (!b2b) @(negedge clk);
        checks++;
        if (cur_rdy !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready dut%0d: req_ready=%b expected 1", which, cur_rdy);
        end
        @(posedge clk); #1;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        req_addr = 15'h7fff; req_wdata = 16'hffff; req_we = ~we;  // busy-time changes must not matter
    endtask

    // Run cycles 1..max after acceptance, drive the fake core A per cycle masks,
    // capture bus state and pop/compare the scoreboard when rsp_valid shows up.
    task automatic collect(input int max, input logic [31:0] rd_mask, input logic [31:0] wr_mask);
        exp_t e;
        rsp_cyc = 0;
        for (int c = 1; c <= max; c++) begin
            fk_rd = rd_mask[c];
            fk_wr = wr_mask[c];
            @(negedge clk);
            cap_ra[c] = cur_ra; cap_wa[c] = cur_wa; cap_wd[c] = cur_wd; cap_rdy[c] = cur_rdy;
            if (cur_rv === 1'b1) begin
                rsp_cyc = c;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected dut%0d: rsp_valid in c%0d with nothing expected", cur, c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.lat || cur_rd !== e.data || cur_re !== e.err) begin
                        errors++;
                        $display("FAIL rsp dut%0d: cycle=%0d data=%h err=%b expected cycle=%0d data=%h err=%b",
                                 cur, c, cur_rd, cur_re, e.lat, e.data, e.err);
                    end
                end
                break;
            end
            @(posedge clk); #1;
        end
        fk_rd = 1'b0;
        fk_wr = 1'b0;
        if (rsp_cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout dut%0d: no rsp_valid within %0d cycles", cur, max);
        end
    endtask

    task automatic test_reset();
        logic [15:0] pl_a [0:2];
        logic [15:0] pl_d [0:2];
        reset = 1'b1; va = 1'b0; vb = 1'b0; vc = 1'b0; cur = 0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;
        fk_rd = 1'b0; fk_wr = 1'b0; fk_raddr = '0; fk_waddr = '0; fk_wdata = '0;
        pl_a[0] = 16'h0010; pl_d[0] = 16'hbeef;
        pl_a[1] = 16'h0020; pl_d[1] = 16'hc0de;
        pl_a[2] = 16'h0050; pl_d[2] = 16'h7777;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            fk_waddr = pl_a[i][14:0]; fk_wdata = pl_d[i]; fk_wr = 1'b1;
            @(posedge clk); #1;
        end
        fk_wr = 1'b0;
        @(negedge clk);
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL rst_ready_a: %b expected 0", rdy_a); end
        checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL rst_ready_b: %b expected 0", rdy_b); end
        checks++; if (rv_a !== 1'b0 || re_a !== 1'b0) begin errors++; $display("FAIL rst_rsp: valid=%b err=%b expected 0 0", rv_a, re_a); end
        checks++; if (rd_a !== 16'h0) begin errors++; $display("FAIL rst_rsp_data: %h expected 0000", rd_a); end
        checks++; if (ra_a !== 16'h0 || wa_a !== 16'h0) begin errors++; $display("FAIL rst_addr: raddr=%h waddr=%h expected 0000 0000", ra_a, wa_a); end
        checks++; if (wd_a !== 16'h0) begin errors++; $display("FAIL rst_wdata: %h expected 0000", wd_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (mem[15'h0010] !== 16'hbeef) begin errors++; $display("FAIL preload: %h expected beef", mem[15'h0010]); end
    endtask

    task automatic test_load_a();
        do_req(0, 1'b0, 15'h0010, 16'h0, 4, 16'hbeef, 1'b0, 1'b0);
        collect(12, 32'h0, 32'h0);
        checks++; if (cap_ra[1] !== {1'b1, 15'h0010}) begin errors++; $display("FAIL load_a_raddr_c1: %h expected %h", cap_ra[1], {1'b1, 15'h0010}); end
        checks++; if (cap_ra[2][16] !== 1'b0) begin errors++; $display("FAIL load_a_raddr_c2_valid: %b expected 0", cap_ra[2][16]); end
        checks++; if (cap_rdy[4] !== 1'b1) begin errors++; $display("FAIL load_a_ready_c4: %b expected 1", cap_rdy[4]); end
    endtask

    task automatic test_load_b_retry();
        fk_raddr = 15'h0021;
        do_req(1, 1'b0, 15'h0020, 16'h0, 7, 16'hc0de, 1'b0, 1'b0);
        collect(16, 32'h0000_0002, 32'h0);
        checks++;
        if ({cap_ra[1][16], cap_ra[2][16], cap_ra[3][16], cap_ra[4][16]} !== 4'b1001) begin
            errors++;
            $display("FAIL load_b_rvalid_c1to4: %b expected 1001",
                     {cap_ra[1][16], cap_ra[2][16], cap_ra[3][16], cap_ra[4][16]});
        end
    endtask

    task automatic test_store_b_retry();
        fk_waddr = 15'h0031; fk_wdata = 16'hdead;
        do_req(1, 1'b1, 15'h0030, 16'h1234, 4, 16'h0000, 1'b0, 1'b0);
        collect(16, 32'h0, 32'h0000_0006);
        checks++;
        if ({cap_wa[1][16], cap_wa[2][16], cap_wa[3][16], cap_wa[4][16]} !== 4'b1110) begin
            errors++;
            $display("FAIL store_b_wvalid_c1to4: %b expected 1110",
                     {cap_wa[1][16], cap_wa[2][16], cap_wa[3][16], cap_wa[4][16]});
        end
        checks++; if (cap_wa[3] !== {1'b1, 15'h0030} || cap_wd[3] !== 16'h1234) begin errors++; $display("FAIL store_b_bus_c3: waddr=%h wdata=%h expected %h 1234", cap_wa[3], cap_wd[3], {1'b1, 15'h0030}); end
        checks++; if (mem[15'h0030] !== 16'h1234) begin errors++; $display("FAIL store_b_mem: %h expected 1234", mem[15'h0030]); end
    endtask

    task automatic test_retry_limit();
        fk_raddr = 15'h0022;
        do_req(2, 1'b0, 15'h0020, 16'h0, 7, 16'h0000, 1'b1, 1'b0);
        collect(16, 32'hffff_fffe, 32'h0);
        checks++; if (cap_rdy[7] !== 1'b1) begin errors++; $display("FAIL limit_ready_c7: %b expected 1", cap_rdy[7]); end
        do_req(2, 1'b0, 15'h0050, 16'h0, 4, 16'h7777, 1'b0, 1'b1);
        collect(12, 32'h0, 32'h0);
    endtask

    task automatic test_reset_midop();
        int pulses;
        do_req(0, 1'b0, 15'h0010, 16'h0, -1, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL midrst_ready_in_reset: %b expected 0", rdy_a); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ra_a[16] !== 1'b0 || wa_a[16] !== 1'b0) begin errors++; $display("FAIL midrst_valid_bits: r=%b w=%b expected 0 0", ra_a[16], wa_a[16]); end
        checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL midrst_idle: req_ready=%b expected 1", rdy_a); end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (rv_a === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_rsp: %0d pulses expected 0", pulses); end
    endtask

    task automatic test_back_to_back();
        do_req(0, 1'b1, 15'h0040, 16'h5a5a, 2, 16'h0000, 1'b0, 1'b0);
        collect(8, 32'h0, 32'h0);
        do_req(0, 1'b0, 15'h0040, 16'h0, 4, 16'h5a5a, 1'b0, 1'b1);
        collect(12, 32'h0, 32'h0);
`ifdef MEM_PORT_RETRY_STATS_EN
        checks++; if (rt_a !== 16'd0) begin errors++; $display("FAIL b2b_retry_total: %0d expected 0", rt_a); end
        checks++; if (sc_a !== 16'd4) begin errors++; $display("FAIL b2b_stall_cycles: %0d expected 4", sc_a); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_a();
        test_load_b_retry();
        test_store_b_retry();
        test_retry_limit();
        test_reset_midop();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
